// File: rtl/amber48_ex_ctrl.sv
// amber48 execute-stage sequencer: ex/result pipeline registers with valid/ready
// handshakes, branch redirect with a squash window, and a held trap request.
package amber48_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_BR_UNCOND,
        OP_BR_EQ
    } amber48_op_e;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_ILLEGAL,
        TRAP_ECALL,
        TRAP_MISALIGN
    } amber48_trap_e;

    typedef struct packed {
        logic                valid;
        amber48_op_e         op;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1_val;
        logic [XLEN-1:0]     rs2_val;
        logic [XLEN-1:0]     imm;
        logic [REG_W-1:0]    rd;
        amber48_trap_e       trap_cause;
    } amber48_execute_in_s;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [REG_W-1:0]    rd;
        logic                wb_en;
        logic [XLEN-1:0]     result;
        logic                branch_taken;
        logic [XLEN-1:0]     branch_target;
        logic                trap;
        amber48_trap_e       trap_cause;
    } amber48_execute_out_s;

endpackage

module amber48_ex_ctrl
    import amber48_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  amber48_execute_in_s  in_pkt_i,
    output amber48_execute_in_s  alu_in_o,
    input  amber48_execute_out_s alu_out_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output amber48_execute_out_s out_pkt_o,
    output logic                 redirect_o,
    output logic [XLEN-1:0]      redirect_pc_o,
    output logic                 trap_req_o,
    output amber48_trap_e        trap_cause_o,
    output logic [XLEN-1:0]      trap_pc_o,
    input  logic                 trap_ack_i
);

    // A zero-length squash window still needs a legal one-bit counter.
    localparam int unsigned CNT_W = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SQUASH,
        ST_TRAP_WAIT
    } state_e;

    state_e               state_q,       state_d;
    logic                 ex_valid_q,    ex_valid_d;
    amber48_execute_in_s  ex_pkt_q,      ex_pkt_d;
    logic                 out_valid_q,   out_valid_d;
    amber48_execute_out_s out_pkt_q,     out_pkt_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    logic                 redirect_q,    redirect_d;
    logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
    logic                 trap_req_q,    trap_req_d;
    amber48_trap_e        trap_cause_q,  trap_cause_d;
    logic [XLEN-1:0]      trap_pc_q,     trap_pc_d;

    logic                 ex_adv_c;
    logic                 in_ready_c;
    logic                 accept_c;
    amber48_execute_in_s  alu_in_c;

    // Handshake qualifiers shared by the next-state logic and the ports.
    always_comb begin
        ex_adv_c   = ex_valid_q && (!out_valid_q || out_ready_i) && (state_q == ST_RUN);
        in_ready_c = (state_q != ST_TRAP_WAIT) && (!ex_valid_q || ex_adv_c);
        accept_c   = in_valid_i && in_ready_c;
        alu_in_c       = ex_pkt_q;
        alu_in_c.valid = ex_valid_q;
    end

    always_comb begin
        state_d       = state_q;
        ex_valid_d    = ex_valid_q;
        ex_pkt_d      = ex_pkt_q;
        out_valid_d   = out_valid_q;
        out_pkt_d     = out_pkt_q;
        cnt_d         = cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        trap_req_d    = trap_req_q;
        trap_cause_d  = trap_cause_q;
        trap_pc_d     = trap_pc_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_RUN: begin
                if (ex_adv_c) begin
                    if (alu_out_i.trap) begin
                        // Trapping packet never reaches memory; anything accepted alongside dies.
                        ex_valid_d   = 1'b0;
                        trap_cause_d = alu_out_i.trap_cause;
                        trap_pc_d    = ex_pkt_q.pc;
                        trap_req_d   = 1'b1;
                        state_d      = ST_TRAP_WAIT;
                    end else if (alu_out_i.branch_taken) begin
                        out_valid_d   = 1'b1;
                        out_pkt_d     = alu_out_i;
                        redirect_d    = 1'b1;
                        redirect_pc_d = alu_out_i.branch_target;
                        ex_valid_d    = 1'b0;
                        if (SQUASH_CYCLES > 0) begin
                            cnt_d   = CNT_W'(SQUASH_CYCLES);
                            state_d = ST_SQUASH;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_pkt_d   = alu_out_i;
                        ex_valid_d  = accept_c;
                        if (accept_c) begin
                            ex_pkt_d = in_pkt_i;
                        end
                    end
                end else if (accept_c) begin
                    ex_valid_d = 1'b1;
                    ex_pkt_d   = in_pkt_i;
                end
            end
            ST_SQUASH: begin
                // Wrong-path packets are swallowed: in_ready stays high, ex stays empty.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TRAP_WAIT: begin
                if (trap_ack_i) begin
                    trap_req_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (flush_i) begin
            state_d     = ST_RUN;
            ex_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            trap_req_d  = 1'b0;
            redirect_d  = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_pkt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_pkt_q     <= '0;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            trap_req_q    <= 1'b0;
            trap_cause_q  <= TRAP_NONE;
            trap_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            ex_pkt_q      <= ex_pkt_d;
            out_valid_q   <= out_valid_d;
            out_pkt_q     <= out_pkt_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            trap_req_q    <= trap_req_d;
            trap_cause_q  <= trap_cause_d;
            trap_pc_q     <= trap_pc_d;
        end
    end

    assign in_ready_o    = in_ready_c;
    assign alu_in_o      = alu_in_c;
    assign out_valid_o   = out_valid_q;
    assign out_pkt_o     = out_pkt_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign trap_req_o    = trap_req_q;
    assign trap_cause_o  = trap_cause_q;
    assign trap_pc_o     = trap_pc_q;

endmodule

// File: tb/tb_amber48_ex_ctrl.sv
// Scoreboard bench for amber48_ex_ctrl with a small behavioural ALU in the loop.
module tb_amber48_ex_ctrl;
    import amber48_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 flush_i = 1'b0;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    amber48_execute_in_s  in_pkt_i = '0;
    amber48_execute_in_s  alu_in_o;
    amber48_execute_out_s alu_out_i;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    amber48_execute_out_s out_pkt_o;
    logic                 redirect_o;
    logic [XLEN-1:0]      redirect_pc_o;
    logic                 trap_req_o;
    amber48_trap_e        trap_cause_o;
    logic [XLEN-1:0]      trap_pc_o;
    logic                 trap_ack_i = 1'b0;

    amber48_ex_ctrl #(.SQUASH_CYCLES(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pkt_i(in_pkt_i),
        .alu_in_o(alu_in_o), .alu_out_i(alu_out_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pkt_o(out_pkt_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .trap_req_o(trap_req_o), .trap_cause_o(trap_cause_o), .trap_pc_o(trap_pc_o),
        .trap_ack_i(trap_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU, combinational from the execute register.
    always_comb begin
        alu_out_i            = '0;
        alu_out_i.valid      = alu_in_o.valid;
        alu_out_i.pc         = alu_in_o.pc;
        alu_out_i.rd         = alu_in_o.rd;
        alu_out_i.wb_en      = (alu_in_o.rd != '0);
        alu_out_i.trap_cause = alu_in_o.trap_cause;
        alu_out_i.trap       = alu_in_o.valid && (alu_in_o.trap_cause != TRAP_NONE);
        case (alu_in_o.op)
            OP_ADD: alu_out_i.result = alu_in_o.rs1_val + alu_in_o.rs2_val;
            OP_SUB: alu_out_i.result = alu_in_o.rs1_val - alu_in_o.rs2_val;
            OP_AND: alu_out_i.result = alu_in_o.rs1_val & alu_in_o.rs2_val;
            OP_OR:  alu_out_i.result = alu_in_o.rs1_val | alu_in_o.rs2_val;
            OP_XOR: alu_out_i.result = alu_in_o.rs1_val ^ alu_in_o.rs2_val;
            OP_BR_UNCOND: begin
                alu_out_i.result        = alu_in_o.pc + 32'd4;
                alu_out_i.branch_taken  = 1'b1;
                alu_out_i.branch_target = alu_in_o.pc + alu_in_o.imm;
            end
            OP_BR_EQ: begin
                alu_out_i.result        = alu_in_o.pc + 32'd4;
                alu_out_i.branch_taken  = (alu_in_o.rs1_val == alu_in_o.rs2_val);
                alu_out_i.branch_target = alu_in_o.pc + alu_in_o.imm;
            end
            default: alu_out_i.result = '0;
        endcase
    end

    typedef struct packed {
        amber48_trap_e   cause;
        logic [XLEN-1:0] pc;
    } trap_exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int first_valid_cyc = -1;
    int redir_cnt = 0;
    int pop_cyc[$];
    amber48_execute_out_s sb_q[$];
    logic [XLEN-1:0]      rq[$];
    trap_exp_t            tq[$];
    logic prev_trap = 1'b0;
    logic prev_redir = 1'b0;
    logic prev_outv = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endfunction

    function automatic amber48_execute_in_s mk_in(input amber48_op_e op, input logic [31:0] pc,
            input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
            input logic [4:0] rd, input amber48_trap_e tc);
        amber48_execute_in_s p;
        p = '0;
        p.valid = 1'b1; p.op = op; p.pc = pc; p.rs1_val = rs1; p.rs2_val = rs2;
        p.imm = imm; p.rd = rd; p.trap_cause = tc;
        return p;
    endfunction

    function automatic amber48_execute_out_s mk_out(input logic [31:0] pc, input logic [4:0] rd,
            input logic [31:0] result, input logic taken, input logic [31:0] target);
        amber48_execute_out_s o;
        o = '0;
        o.valid = 1'b1; o.pc = pc; o.rd = rd; o.wb_en = 1'b1; o.result = result;
        o.branch_taken = taken; o.branch_target = target; o.trap_cause = TRAP_NONE;
        return o;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a result, redirect or trap.
    always @(negedge clk_i) begin
        amber48_execute_out_s eo;
        trap_exp_t et;
        logic [XLEN-1:0] er;
        if (rst_i) begin
            prev_trap  = 1'b0;
            prev_redir = 1'b0;
            prev_outv  = 1'b0;
        end else begin
            if (out_valid_o && !prev_outv && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected act=%0h exp=none", out_pkt_o);
                end else begin
                    eo = sb_q.pop_front();
                    chk("sb_out", 160'(out_pkt_o), 160'(eo));
                    pop_cyc.push_back(cyc);
                end
            end
            if (redirect_o) begin
                redir_cnt++;
                chk("redir_width", 160'(prev_redir), 160'(1'b0));
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL redir_unexpected act=%0h exp=none", redirect_pc_o);
                end else begin
                    er = rq.pop_front();
                    chk("redir_pc", 160'(redirect_pc_o), 160'(er));
                    chk("redir_align", 160'({out_valid_o, out_pkt_o.branch_taken, out_pkt_o.branch_target}),
                        160'({1'b1, 1'b1, er}));
                end
            end
            if (trap_req_o && !prev_trap) begin
                if (tq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL trap_unexpected act=%0h exp=none", trap_pc_o);
                end else begin
                    et = tq.pop_front();
                    chk("trap_cause", 160'(trap_cause_o), 160'(et.cause));
                    chk("trap_pc", 160'(trap_pc_o), 160'(et.pc));
                end
            end
            prev_trap  = trap_req_o;
            prev_redir = redirect_o;
            prev_outv  = out_valid_o;
        end
    end

    task automatic send(input amber48_execute_in_s p);
        int n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        in_valid_i = 1'b1;
        in_pkt_i   = p;
        while (!rdy) begin
            @(negedge clk_i);
            rdy = in_ready_o;
            if (rdy) last_acc_cyc = cyc;
            @(posedge clk_i); #1;
            n++;
            if (!rdy && n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout act=stalled exp=accept pc=%0h", p.pc);
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic wait_trap(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!trap_req_o && n < 20);
        if (!trap_req_o) begin
            checks++; errors++;
            $display("FAIL %s act=no_trap exp=trap_req", name);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 160'(out_valid_o), 160'(1'b0));
        chk({tag, "_out_pkt"}, 160'(out_pkt_o), 160'(0));
        chk({tag, "_alu_in"}, 160'(alu_in_o), 160'(0));
        chk({tag, "_redirect"}, 160'({redirect_o, redirect_pc_o}), 160'(0));
        chk({tag, "_trap_req"}, 160'(trap_req_o), 160'(1'b0));
        chk({tag, "_trap_info"}, 160'({trap_cause_o, trap_pc_o}), 160'({TRAP_NONE, 32'h0}));
        chk({tag, "_in_ready"}, 160'(in_ready_o), 160'(1'b1));
    endtask

    initial begin
        int acc0;
        amber48_execute_out_s hold_exp;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outputs("rst");
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Streaming ADDs, one per cycle
        pop_cyc.delete();
        first_valid_cyc = -1;
        out_ready_i = 1'b1;
        sb_q.push_back(mk_out(32'h10, 5'd1, 32'd12, 1'b0, 32'h0));
        sb_q.push_back(mk_out(32'h14, 5'd2, 32'd123, 1'b0, 32'h0));
        sb_q.push_back(mk_out(32'h18, 5'd3, 32'd1, 1'b0, 32'h0));
        send(mk_in(OP_ADD, 32'h10, 32'd5, 32'd7, 32'h0, 5'd1, TRAP_NONE));
        acc0 = last_acc_cyc;
        send(mk_in(OP_ADD, 32'h14, 32'd100, 32'd23, 32'h0, 5'd2, TRAP_NONE));
        send(mk_in(OP_ADD, 32'h18, 32'hFFFF_FFFF, 32'd2, 32'h0, 5'd3, TRAP_NONE));
        idle(5);
        chk("t1_latency", 160'(first_valid_cyc - acc0), 160'(2));
        chk("t1_count", 160'(pop_cyc.size()), 160'(3));
        if (pop_cyc.size() == 3) begin
            chk("t1_tput_a", 160'(pop_cyc[1] - pop_cyc[0]), 160'(1));
            chk("t1_tput_b", 160'(pop_cyc[2] - pop_cyc[1]), 160'(1));
        end
        chk("t1_drain", 160'(sb_q.size()), 160'(0));

        // Backpressure
        out_ready_i = 1'b0;
        hold_exp = mk_out(32'h20, 5'd4, 32'd42, 1'b0, 32'h0);
        sb_q.push_back(hold_exp);
        sb_q.push_back(mk_out(32'h24, 5'd5, 32'h0000_F000, 1'b0, 32'h0));
        send(mk_in(OP_SUB, 32'h20, 32'd50, 32'd8, 32'h0, 5'd4, TRAP_NONE));
        send(mk_in(OP_AND, 32'h24, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd5, TRAP_NONE));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t2_in_ready", 160'(in_ready_o), 160'(1'b0));
            chk("t2_hold", 160'({out_valid_o, out_pkt_o}), 160'({1'b1, hold_exp}));
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        sb_q.push_back(mk_out(32'h28, 5'd6, 32'h3F, 1'b0, 32'h0));
        send(mk_in(OP_OR, 32'h28, 32'h0F, 32'h30, 32'h0, 5'd6, TRAP_NONE));
        idle(5);
        chk("t2_drain", 160'(sb_q.size()), 160'(0));

        // Taken branch: redirect plus two squashed packets
        redir_cnt = 0;
        sb_q.push_back(mk_out(32'h100, 5'd1, 32'h104, 1'b1, 32'h140));
        rq.push_back(32'h140);
        send(mk_in(OP_BR_UNCOND, 32'h100, 32'h0, 32'h0, 32'h40, 5'd1, TRAP_NONE));
        send(mk_in(OP_ADD, 32'h104, 32'd1, 32'd1, 32'h0, 5'd2, TRAP_NONE));
        send(mk_in(OP_ADD, 32'h108, 32'd2, 32'd2, 32'h0, 5'd3, TRAP_NONE));
        sb_q.push_back(mk_out(32'h10C, 5'd7, 32'hF0, 1'b0, 32'h0));
        send(mk_in(OP_XOR, 32'h10C, 32'hFF, 32'h0F, 32'h0, 5'd7, TRAP_NONE));
        idle(5);
        chk("t3_drain", 160'(sb_q.size()), 160'(0));
        chk("t3_redir_cnt", 160'(redir_cnt), 160'(1));
        chk("t3_redir_q", 160'(rq.size()), 160'(0));

        // Trap request held until acknowledged
        tq.push_back('{cause: TRAP_ILLEGAL, pc: 32'h200});
        send(mk_in(OP_ADD, 32'h200, 32'd1, 32'd1, 32'h0, 5'd8, TRAP_ILLEGAL));
        wait_trap("t4_trap_rise");
        chk("t4_in_ready", 160'(in_ready_o), 160'(1'b0));
        chk("t4_no_out", 160'(out_valid_o), 160'(1'b0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("t4_held", 160'({trap_req_o, in_ready_o, trap_cause_o, trap_pc_o}),
                160'({1'b1, 1'b0, TRAP_ILLEGAL, 32'h200}));
        end
        @(posedge clk_i); #1;
        trap_ack_i = 1'b1;
        @(negedge clk_i);
        chk("t4_ack_cycle", 160'({trap_req_o, in_ready_o}), 160'({1'b1, 1'b0}));
        @(posedge clk_i); #1;
        trap_ack_i = 1'b0;
        @(negedge clk_i);
        chk("t4_released", 160'({trap_req_o, in_ready_o}), 160'({1'b0, 1'b1}));
        @(posedge clk_i); #1;
        sb_q.push_back(mk_out(32'h204, 5'd9, 32'd7, 1'b0, 32'h0));
        send(mk_in(OP_ADD, 32'h204, 32'd3, 32'd4, 32'h0, 5'd9, TRAP_NONE));
        idle(4);
        chk("t4_drain", 160'(sb_q.size()), 160'(0));
        chk("t4_trap_q", 160'(tq.size()), 160'(0));

        // Flush with ex and out full and a branch waiting in ex
        out_ready_i = 1'b0;
        send(mk_in(OP_ADD, 32'h300, 32'd1, 32'd2, 32'h0, 5'd10, TRAP_NONE));
        send(mk_in(OP_BR_UNCOND, 32'h304, 32'h0, 32'h0, 32'h20, 5'd11, TRAP_NONE));
        @(negedge clk_i);
        chk("t5_pre", 160'({out_valid_o, alu_in_o.valid}), 160'({1'b1, 1'b1}));
        @(posedge clk_i); #1;
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_pkt_i   = mk_in(OP_ADD, 32'h308, 32'd5, 32'd5, 32'h0, 5'd12, TRAP_NONE);
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t5_after", 160'({out_valid_o, redirect_o, in_ready_o, alu_in_o.valid}),
            160'({1'b0, 1'b0, 1'b1, 1'b0}));
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        idle(5);
        chk("t5_drain", 160'(sb_q.size()), 160'(0));

        // Asynchronous reset while waiting on a trap ack
        tq.push_back('{cause: TRAP_ECALL, pc: 32'h240});
        send(mk_in(OP_ADD, 32'h240, 32'd0, 32'd0, 32'h0, 5'd13, TRAP_ECALL));
        wait_trap("t6_trap_rise");
        #2;
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        chk("t6_trap_q", 160'(tq.size()), 160'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        idle(3);
        @(negedge clk_i);
        chk("t6_quiet", 160'({trap_req_o, redirect_o, out_valid_o}), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
